longop_scoreboard: RTL and testbench
====================================

Name: longop_scoreboard

Overview:
- Issue-side hazard tracker for long-latency results: iterative multiply/divide and non-blocking loads.
- Sits beside the ID stage.
- Records each destination register a long op will write. Clears the record when the long unit writes back.
- Stalls ID on RAW/WAW hazards that the EX/MEM/WB forwarding paths cannot cover.

Parameters:
- MAX_OUTSTANDING, 4, maximum long ops in flight; ID stalls new long ops at this limit.
- CNT_W, 3, width of the outstanding counter; must satisfy 2^CNT_W > MAX_OUTSTANDING.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- flush  input  1  kills the ID instruction this cycle; suppresses issue.
- id_fire  input  1  ID instruction advances to EX this cycle (pipeline's raw advance request).
- id_rs1  input  5  ID source register 1.
- id_rs2  input  5  ID source register 2.
- id_use_rs1  input  1  ID instruction reads rs1.
- id_use_rs2  input  1  ID instruction reads rs2.
- id_rd  input  5  ID destination register.
- id_reg_write  input  1  ID instruction writes rd.
- id_long_op  input  1  ID instruction is a long-latency op.
- wb_valid  input  1  long unit writes back this cycle.
- wb_rd  input  5  long unit writeback register.
- stall  output  1  hold PC and IF/ID; insert bubble into EX.
- pending_mask  output  32  bit r set = register r awaiting long-op writeback; bit 0 always 0.
- outstanding  output  CNT_W  count of long ops in flight.
- sb_err  output  1  sticky protocol-error flag.

Behaviour:
- Reset (async, immediate): pending_mask=0, outstanding=0, sb_err=0. stall therefore 0 once rst falls.
- Combinational hazard terms, from current state only:
  - raw1 = id_use_rs1 & id_rs1!=0 & pending[id_rs1].
  - raw2 = id_use_rs2 & id_rs2!=0 & pending[id_rs2].
  - waw = id_reg_write & id_rd!=0 & pending[id_rd].
  - full = id_long_op & (outstanding==MAX_OUTSTANDING).
- stall = raw1 | raw2 | waw | full. Zero-cycle latency, same cycle as the ID inputs.
- issue = id_fire & !stall & !flush. Only issue updates state; id_fire under stall or flush is ignored.
- set_en = issue & id_long_op & id_reg_write & id_rd!=0. Sets pending[id_rd] at the next edge.
- A long op with rd=x0 or no reg_write still occupies a slot:
  - outstanding increments on issue & id_long_op, regardless of rd.
  - Such ops retire via wb_valid with wb_rd=0.
- clr_en = wb_valid:
  - clears pending[wb_rd] if wb_rd!=0;
  - decrements outstanding if outstanding>0.
- Simultaneous increment and decrement: outstanding unchanged.
- Simultaneous set and clear of the same register: the set wins; the bit stays 1. Only reachable via the bypass feature or x0.
- Error cases (each sets sb_err, sticky until rst):
  - wb_valid with wb_rd!=0 and pending[wb_rd]==0: bit stays 0.
  - wb_valid with outstanding==0: counter holds at 0, no underflow.
- Overflow impossible: full blocks issue at the limit.
- flush does not clear pending or outstanding. Already-issued long ops still complete and write back.
- pending_mask[0] is hard-wired 0.

Optional Feature:
- Macro: SCOREBOARD_WB_BYPASS_EN.
- Defined:
  - A hazard term on register r is masked when wb_valid & wb_rd==r & r!=0 in the same cycle. The forwarding path supplies the writeback value.
  - full is masked when wb_valid is 1 (a slot frees this cycle).
  - Saves one stall cycle per dependent op.
- Undefined: stall uses registered state only. Dependents issue the cycle after writeback.

Test Plan:
- Reset mid-run:
  - Stimulus: issue long ops to x5 and x6, then assert rst asynchronously between edges.
  - Required: pending_mask=0, outstanding=0, stall=0, sb_err=0 immediately.
- RAW stall:
  - Stimulus: issue long op rd=x7, then ID reads rs1=x7; wb_valid wb_rd=x7 three cycles later.
  - Required: stall=1 until the writeback edge (without bypass). With SCOREBOARD_WB_BYPASS_EN, stall drops in the writeback cycle.
- WAW and x0:
  - Stimulus: pending x9, ID writes x9; then ID writes x0 with x0 long-issued.
  - Required: stall=1 for x9. No stall for x0, pending_mask[0]=0, outstanding increments.
- Capacity:
  - Stimulus: issue 4 long ops to x1..x4, then a 5th long op.
  - Required: stall=1, outstanding=4. After wb_rd=x2: outstanding=3, pending_mask=0x1A, 5th issues.
- Flush and simultaneity:
  - Stimulus: id_fire with flush=1 for long op x10; separately, issue one long op while wb retires another.
  - Required: flush leaves pending[10]=0 and outstanding unchanged. Simultaneous case holds outstanding constant.
- Protocol error:
  - Stimulus: wb_valid wb_rd=x12 with nothing pending; then wb_valid with outstanding=0.
  - Required: sb_err=1 and stays 1. outstanding stays 0, pending_mask stays 0.

Source files
------------

// File: rtl/longop_scoreboard_if.sv
// ---------------------------------------------------------------------------
// longop_scoreboard_if
// Bundles the ID-stage request, the long-unit writeback and the scoreboard
// status outputs into one interface.
//   master : the pipeline side (drives ID / writeback, reads stall/status)
//   slave  : the scoreboard itself
// Signals:
//   flush, id_fire, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
//   id_reg_write, id_long_op  - ID-stage instruction description
//   wb_valid, wb_rd           - long-unit writeback
//   stall                     - hold PC and IF/ID, bubble into EX
//   pending_mask              - registers awaiting long-op writeback
//   outstanding               - long ops in flight
//   sb_err                    - sticky protocol-error flag
// ---------------------------------------------------------------------------
interface longop_scoreboard_if #(
  parameter int CNT_W = 3
);
  logic             flush;
  logic             id_fire;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       id_rd;
  logic             id_reg_write;
  logic             id_long_op;
  logic             wb_valid;
  logic [4:0]       wb_rd;
  logic             stall;
  logic [31:0]      pending_mask;
  logic [CNT_W-1:0] outstanding;
  logic             sb_err;

  modport master (
    output flush, id_fire, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_reg_write, id_long_op, wb_valid, wb_rd,
    input  stall, pending_mask, outstanding, sb_err
  );

  modport slave (
    input  flush, id_fire, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_reg_write, id_long_op, wb_valid, wb_rd,
    output stall, pending_mask, outstanding, sb_err
  );
endinterface

// File: rtl/longop_scoreboard.sv
// ---------------------------------------------------------------------------
// longop_scoreboard
// Issue-side hazard tracker for long-latency results (iterative mul/div,
// non-blocking loads). Records the destination of every issued long op,
// clears it on long-unit writeback, and stalls ID on RAW/WAW hazards against
// those registers or when too many long ops are in flight.
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   sb   - longop_scoreboard_if.slave (ID request, writeback, status)
//
// Parameters:
//   MAX_OUTSTANDING - long ops allowed in flight
//   CNT_W           - outstanding counter width, 2**CNT_W > MAX_OUTSTANDING
//
// Optional feature macro: SCOREBOARD_WB_BYPASS_EN
//   When defined, a hazard on the register being written back this cycle is
//   ignored (the forwarding path supplies the value) and the capacity stall
//   is ignored while a writeback frees a slot. When undefined, stall depends
//   on registered state only.
// ---------------------------------------------------------------------------
module longop_scoreboard #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 3
) (
  input  logic               clk,
  input  logic               rst,
  longop_scoreboard_if.slave sb
);

  if ((2 ** CNT_W) <= MAX_OUTSTANDING) begin : g_cnt_w_check
    $error("longop_scoreboard: CNT_W too narrow for MAX_OUTSTANDING");
  end

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic [31:0]      pend_q;
  logic [31:0]      pend_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             err_q;
  logic             err_d;

  logic byp_rs1;
  logic byp_rs2;
  logic byp_rd;
  logic byp_full;

`ifdef SCOREBOARD_WB_BYPASS_EN
  // x0 is excluded by the hazard terms themselves, so no r!=0 test here.
  assign byp_rs1  = sb.wb_valid && (sb.wb_rd == sb.id_rs1);
  assign byp_rs2  = sb.wb_valid && (sb.wb_rd == sb.id_rs2);
  assign byp_rd   = sb.wb_valid && (sb.wb_rd == sb.id_rd);
  assign byp_full = sb.wb_valid;
`else
  assign byp_rs1  = 1'b0;
  assign byp_rs2  = 1'b0;
  assign byp_rd   = 1'b0;
  assign byp_full = 1'b0;
`endif

  logic raw1;
  logic raw2;
  logic waw;
  logic full;
  logic stall_c;
  logic issue;
  logic inc;
  logic dec;
  logic set_en;

  assign raw1 = sb.id_use_rs1 && (sb.id_rs1 != 5'd0) && pend_q[sb.id_rs1] && !byp_rs1;
  assign raw2 = sb.id_use_rs2 && (sb.id_rs2 != 5'd0) && pend_q[sb.id_rs2] && !byp_rs2;
  assign waw  = sb.id_reg_write && (sb.id_rd != 5'd0) && pend_q[sb.id_rd] && !byp_rd;
  assign full = sb.id_long_op && (cnt_q == MAX_CNT) && !byp_full;

  assign stall_c = raw1 || raw2 || waw || full;
  assign issue   = sb.id_fire && !stall_c && !sb.flush;

  // Every issued long op takes a slot, even without a tracked destination;
  // those retire through a writeback to x0.
  assign inc    = issue && sb.id_long_op;
  assign set_en = inc && sb.id_reg_write && (sb.id_rd != 5'd0);
  assign dec    = sb.wb_valid && (cnt_q != '0);

  always_comb begin
    pend_d = pend_q;
    if (sb.wb_valid && (sb.wb_rd != 5'd0)) begin
      pend_d[sb.wb_rd] = 1'b0;
    end
    // Applied after the clear so a same-register set wins.
    if (set_en) begin
      pend_d[sb.id_rd] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({inc, dec})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Writeback to a register that is not pending, or with nothing in flight.
  always_comb begin
    err_d = err_q;
    if (sb.wb_valid) begin
      if ((sb.wb_rd != 5'd0) && !pend_q[sb.wb_rd]) begin
        err_d = 1'b1;
      end
      if (cnt_q == '0) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign sb.stall        = stall_c;
  assign sb.pending_mask = {pend_q[31:1], 1'b0};
  assign sb.outstanding  = cnt_q;
  assign sb.sb_err       = err_q;

endmodule

// File: tb/tb_longop_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_longop_scoreboard
// Directed scenarios followed by randomized traffic, all compared against a
// behavioural model (register set as a bit array, in-flight count as an int).
// ---------------------------------------------------------------------------
module tb_longop_scoreboard;
  localparam int MAX   = 4;
  localparam int CNT_W = 3;
`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  longop_scoreboard_if #(.CNT_W(CNT_W)) ifc ();

  longop_scoreboard #(.MAX_OUTSTANDING(MAX), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (ifc)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit m_pend[32];
  int m_out;
  bit m_err;

  // Last observed DUT values (sampled at negedge inside cyc)
  logic        obs_stall;
  logic [31:0] obs_mask;
  logic [31:0] obs_out;
  logic        obs_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    for (int r = 1; r < 32; r++) m[r] = m_pend[r];
    return m;
  endfunction

  function automatic bit haz(input logic [4:0] r, input bit wbv, input logic [4:0] wbr);
    bit h = (r != 0) && m_pend[r];
    if (BYP && wbv && wbr == r) h = 1'b0;
    return h;
  endfunction

  function automatic bit model_stall(input logic [4:0] rs1, rs2, input bit u1, u2,
                                     input logic [4:0] rd, input bit rw, lng, wbv,
                                     input logic [4:0] wbr);
    bit full = lng && (m_out == MAX) && !(BYP && wbv);
    return (u1 && haz(rs1, wbv, wbr)) || (u2 && haz(rs2, wbv, wbr)) ||
           (rw && haz(rd, wbv, wbr)) || full;
  endfunction

  task automatic drive_idle();
    ifc.flush = 0; ifc.id_fire = 0; ifc.id_rs1 = 0; ifc.id_rs2 = 0;
    ifc.id_use_rs1 = 0; ifc.id_use_rs2 = 0; ifc.id_rd = 0;
    ifc.id_reg_write = 0; ifc.id_long_op = 0; ifc.wb_valid = 0; ifc.wb_rd = 0;
  endtask

  // One clock cycle: drive, check everything at negedge, advance model.
  task automatic cyc(input bit fire, fl, input logic [4:0] rs1, rs2, input bit u1, u2,
                     input logic [4:0] rd, input bit rw, lng, wbv, input logic [4:0] wbr);
    bit e_stall;
    bit iss;
    int old_out;
    ifc.id_fire = fire; ifc.flush = fl; ifc.id_rs1 = rs1; ifc.id_rs2 = rs2;
    ifc.id_use_rs1 = u1; ifc.id_use_rs2 = u2; ifc.id_rd = rd;
    ifc.id_reg_write = rw; ifc.id_long_op = lng; ifc.wb_valid = wbv; ifc.wb_rd = wbr;
    e_stall = model_stall(rs1, rs2, u1, u2, rd, rw, lng, wbv, wbr);
    @(negedge clk);
    obs_stall = ifc.stall;
    obs_mask  = ifc.pending_mask;
    obs_out   = 32'(ifc.outstanding);
    obs_err   = ifc.sb_err;
    chk("stall", 32'(obs_stall), 32'(e_stall));
    chk("pending_mask", obs_mask, model_mask());
    chk("outstanding", obs_out, 32'(m_out));
    chk("sb_err", 32'(obs_err), 32'(m_err));
    // Model update from the rules: writeback first, then issue (issue wins).
    iss = fire && !e_stall && !fl;
    old_out = m_out;
    if (wbv) begin
      if (wbr != 0) begin
        if (!m_pend[wbr]) m_err = 1'b1;
        m_pend[wbr] = 1'b0;
      end
      if (old_out == 0) m_err = 1'b1;
      else m_out--;
    end
    if (iss && lng) begin
      m_out++;
      if (rw && rd != 0) m_pend[rd] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit wbv = 0, input logic [4:0] wbr = 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, wbv, wbr);
  endtask

  task automatic ld(input logic [4:0] rd, input bit wbv = 0, input logic [4:0] wbr = 0);
    cyc(1, 0, 0, 0, 0, 0, rd, 1, 1, wbv, wbr);
  endtask

  // Asserts rst between clock edges and checks the outputs clear at once.
  task automatic mid_reset();
    drive_idle();
    #2 rst = 1'b1;
    #1;
    chk("rst_mask", ifc.pending_mask, 32'h0);
    chk("rst_out", 32'(ifc.outstanding), 32'h0);
    chk("rst_stall", 32'(ifc.stall), 32'h0);
    chk("rst_err", 32'(ifc.sb_err), 32'h0);
    for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;
    m_out = 0;
    m_err = 1'b0;
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] pick_pending();
    logic [4:0] q[$];
    for (int r = 1; r < 32; r++) if (m_pend[r]) q.push_back(5'(r));
    if (q.size() == 0) return 5'd0;
    return q[$urandom_range(0, q.size() - 1)];
  endfunction

  function automatic int n_pending();
    int n = 0;
    for (int r = 1; r < 32; r++) n += int'(m_pend[r]);
    return n;
  endfunction

  function automatic logic [4:0] pick_reg();
    logic [4:0] p = pick_pending();
    if (p != 0 && $urandom_range(0, 1) == 1) return p;
    return 5'($urandom_range(0, 15));
  endfunction

  initial begin
    drive_idle();
    m_out = 0;
    m_err = 0;
    for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;
    rst = 1'b1;
    #12;
    chk("init_mask", ifc.pending_mask, 32'h0);
    chk("init_out", 32'(ifc.outstanding), 32'h0);
    chk("init_err", 32'(ifc.sb_err), 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset mid-run
    ld(5);
    ld(6);
    mid_reset();

    // RAW stall on x7, writeback in the third dependent cycle
    ld(7);
    cyc(1, 0, 7, 0, 1, 0, 8, 1, 0, 0, 0);
    chk("raw_hold", 32'(obs_stall), 32'h1);
    cyc(1, 0, 7, 0, 1, 0, 8, 1, 0, 0, 0);
    cyc(1, 0, 7, 0, 1, 0, 8, 1, 0, 1, 7);
    chk("raw_wb_cycle", 32'(obs_stall), BYP ? 32'h0 : 32'h1);
    cyc(1, 0, 7, 0, 1, 0, 8, 1, 0, 0, 0);
    chk("raw_release", 32'(obs_stall), 32'h0);

    // WAW on x9, then long op to x0
    ld(9);
    cyc(1, 0, 0, 0, 0, 0, 9, 1, 0, 0, 0);
    chk("waw_stall", 32'(obs_stall), 32'h1);
    idle(1, 9);
    ld(0);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("x0_no_stall", 32'(obs_stall), 32'h0);
    chk("x0_out", obs_out, 32'h1);
    chk("x0_mask0", 32'(obs_mask[0]), 32'h0);
    idle(1, 0);

    // Capacity
    for (int r = 1; r <= 4; r++) ld(5'(r));
    cyc(1, 0, 0, 0, 0, 0, 5, 1, 1, 0, 0);
    chk("cap_stall", 32'(obs_stall), 32'h1);
    chk("cap_out", obs_out, 32'h4);
    idle(1, 2);
    ld(5);
    chk("cap_after_out", obs_out, 32'h3);
    chk("cap_after_mask", obs_mask, 32'h1A);
    chk("cap_5th_issue", 32'(obs_stall), 32'h0);
    idle(1, 1);
    chk("cap_5th_set", obs_mask, 32'h3A);
    idle(1, 3);
    idle(1, 4);
    idle(1, 5);

    // Flush suppresses issue
    cyc(1, 1, 0, 0, 0, 0, 10, 1, 1, 0, 0);
    idle();
    chk("flush_mask10", 32'(obs_mask[10]), 32'h0);
    chk("flush_out", obs_out, 32'h0);

    // Simultaneous issue and retire
    ld(11);
    ld(13, 1, 11);
    idle();
    chk("sim_out", obs_out, 32'h1);
    chk("sim_mask", obs_mask, 32'h2000);
    idle(1, 13);

    // Protocol errors
    idle(1, 12);
    idle();
    chk("err_set", 32'(obs_err), 32'h1);
    chk("err_out", obs_out, 32'h0);
    chk("err_mask", obs_mask, 32'h0);
    idle(1, 0);
    idle();
    chk("err_sticky", 32'(obs_err), 32'h1);
    chk("err_no_underflow", obs_out, 32'h0);

    mid_reset();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit fire, fl, u1, u2, rw, lng, wbv;
      logic [4:0] rs1, rs2, rd, wbr;
      fire = ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 7) == 0);
      rs1  = pick_reg();
      rs2  = pick_reg();
      u1   = 1'($urandom_range(0, 1));
      u2   = 1'($urandom_range(0, 1));
      rd   = pick_reg();
      rw   = ($urandom_range(0, 3) != 0);
      lng  = ($urandom_range(0, 2) == 0);
      wbv  = 1'b0;
      wbr  = 5'd0;
      if ($urandom_range(0, 59) == 0) begin
        wbv = 1'b1;
        wbr = 5'($urandom_range(0, 31));
      end else if (m_out > 0 && $urandom_range(0, 2) == 0) begin
        wbv = 1'b1;
        if (n_pending() < m_out && $urandom_range(0, 1) == 1) wbr = 5'd0;
        else wbr = pick_pending();
      end
      cyc(fire, fl, rs1, rs2, u1, u2, rd, rw, lng, wbv, wbr);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
